load_store_unit: RTL and testbench

- Sits directly upstream of memory_v2. Converts core load/store requests (byte address, funct3 size/sign) into memory_v2's word-addressed, single-write-enable interface.
- memory_v2 has no byte enables, so sub-word stores are done as read-modify-write (RMW).
- Returns sign- or zero-extended load data, or an error, through a valid/ready response handshake.

---
 rtl/load_store_unit.sv | 203 ++++++++++++++++++++
 tb/tb_load_store_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte-addressed load/store front end for word-addressed memory_v2 (RMW for SB/SH)
// Optional build macro LSU_STATS_EN adds saturating load/store/fault response counters.
module load_store_unit #(
    parameter int addr_width   = 10,
    parameter int data_width   = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_addr,
    input  logic [data_width-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [data_width-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic [addr_width-1:0] mem_addr,
    output logic [data_width-1:0] mem_data_in,
    input  logic [data_width-1:0] mem_data_out,
    output logic                  mem_write_enable
`ifdef LSU_STATS_EN
    ,
    output logic [15:0]           stat_loads,
    output logic [15:0]           stat_stores,
    output logic [15:0]           stat_faults
`endif
);

    typedef enum logic [1:0] {IDLE, RD, WR, RESP} state_t;

    localparam int cnt_w = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);
    localparam logic [cnt_w-1:0] lat_last = cnt_w'(READ_LATENCY);

    state_t state, state_next;

    logic [2:0]       f3_q;
    logic             we_q;
    logic [15:0]      wdata_q;
    logic [1:0]       off_q;
    logic [cnt_w-1:0] lat_cnt;

    logic        accept;
    logic        f3_ok;
    logic        misaligned;
    logic        out_of_range;
    logic        req_err;
    logic        is_sw;
    logic [4:0]  shamt;
    logic [31:0] shifted;
    logic [31:0] load_val;
    logic [31:0] lane_mask;
    logic [31:0] lane_data;
    logic [31:0] merged;

    assign req_ready        = (state == IDLE);
    assign accept           = req_valid && req_ready;
    assign mem_write_enable = (state == WR) && !rst;
    assign is_sw            = req_we && (req_funct3 == 3'b010);

    always_comb begin
        f3_ok = 1'b0;
        case (req_funct3)
            3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
            3'b100, 3'b101:         f3_ok = !req_we;
            default:                f3_ok = 1'b0;
        endcase
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = (req_addr >> (addr_width + 2)) != 32'd0;
        req_err      = !f3_ok || misaligned || out_of_range;
    end

    // Lane extraction for loads and lane replacement for sub-word stores share one shift amount.
    always_comb begin
        shamt     = {off_q, 3'b000};
        shifted   = mem_data_out >> shamt;
        load_val  = 32'd0;
        lane_mask = 32'd0;
        lane_data = 32'd0;
        case (f3_q)
            3'b000:  load_val = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_val = {{16{shifted[15]}}, shifted[15:0]};
            3'b010:  load_val = mem_data_out;
            3'b100:  load_val = {24'd0, shifted[7:0]};
            3'b101:  load_val = {16'd0, shifted[15:0]};
            default: load_val = 32'd0;
        endcase
        if (f3_q[0]) begin
            lane_mask = 32'h0000_FFFF << shamt;
            lane_data = {16'd0, wdata_q} << shamt;
        end else begin
            lane_mask = 32'h0000_00FF << shamt;
            lane_data = {24'd0, wdata_q[7:0]} << shamt;
        end
        merged = (mem_data_out & ~lane_mask) | lane_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (req_err)    state_next = RESP;
                    else if (is_sw) state_next = WR;
                    else            state_next = RD;
                end
            end
            RD: begin
                if (lat_cnt == lat_last) state_next = we_q ? WR : RESP;
            end
            WR:      state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            f3_q        <= 3'd0;
            we_q        <= 1'b0;
            wdata_q     <= 16'd0;
            off_q       <= 2'd0;
            lat_cnt     <= '0;
            mem_addr    <= '0;
            mem_data_in <= '0;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q     <= req_funct3;
                        we_q     <= req_we;
                        wdata_q  <= req_wdata[15:0];
                        off_q    <= req_addr[1:0];
                        lat_cnt  <= '0;
                        mem_addr <= req_addr[addr_width+1:2];
                        if (req_err) begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                            rsp_rdata <= '0;
                        end else if (is_sw) begin
                            mem_data_in <= req_wdata;
                        end
                    end
                end
                RD: begin
                    if (lat_cnt == lat_last) begin
                        if (we_q) begin
                            mem_data_in <= merged;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                            rsp_rdata <= load_val;
                        end
                    end else begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                WR: begin
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                    rsp_rdata <= '0;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef LSU_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_loads  <= 16'd0;
            stat_stores <= 16'd0;
            stat_faults <= 16'd0;
        end else if (state == RESP && rsp_ready) begin
            if (rsp_err) begin
                if (stat_faults != 16'hFFFF) stat_faults <= stat_faults + 16'd1;
            end else if (we_q) begin
                if (stat_stores != 16'hFFFF) stat_stores <= stat_stores + 16'd1;
            end else begin
                if (stat_loads != 16'hFFFF) stat_loads <= stat_loads + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit against a memory_v2 model
module tb_load_store_unit;
    localparam int AW = 10;
    localparam int RL = 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_in;
    logic [31:0]   mem_data_out;
    logic          mem_write_enable;
`ifdef LSU_STATS_EN
    logic [15:0]   stat_loads, stat_stores, stat_faults;
`endif

    load_store_unit #(.addr_width(AW), .data_width(32), .READ_LATENCY(RL)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_write_enable(mem_write_enable)
`ifdef LSU_STATS_EN
        , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_faults(stat_faults)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int n_loads = 0, n_stores = 0, n_faults = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    // memory_v2 model: one-cycle registered read, write on the clock edge
    logic [31:0] mem [0:(1<<AW)-1];
    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = 32'd0;
        mem_data_out = 32'd0;
    end
    always @(posedge clk) begin
        if (mem_write_enable) mem[mem_addr] <= mem_data_in;
        mem_data_out <= mem[mem_addr];
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          c0;
        int          lat;
        int          kind;
    } rsp_t;
    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    rsp_t rq[$];
    wr_t  wq[$];
    rsp_t e;
    wr_t  w;
    bit   seen = 0;

    always begin
        @(negedge clk);
        #2;
        if (rst) begin
            seen = 0;
        end else begin
            if (mem_write_enable) begin
                if (wq.size() == 0) begin
                    check("unexpected_write", 32'd1, 32'd0);
                end else begin
                    w = wq.pop_front();
                    check("wr_addr", 32'(mem_addr), 32'(w.addr));
                    check("wr_data", mem_data_in, w.data);
                end
            end
            if (rsp_valid) begin
                if (!seen) begin
                    seen = 1;
                    if (rq.size() == 0) check("unexpected_rsp", 32'd1, 32'd0);
                    else check("rsp_latency", 32'(cyc - rq[0].c0), 32'(rq[0].lat));
                end
                if (rsp_ready) begin
                    if (rq.size() > 0) begin
                        e = rq.pop_front();
                        check("rsp_rdata", rsp_rdata, e.rdata);
                        check("rsp_err", 32'(rsp_err), 32'(e.err));
                        if (e.kind == 0) n_loads++;
                        else if (e.kind == 1) n_stores++;
                        else n_faults++;
                    end
                    seen = 0;
                end
            end
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err,
                         input int lat, input int kind, input bit do_wr, input logic [31:0] wexp,
                         input bit push, output int c0);
        int n;
        rsp_t r;
        wr_t  x;
        @(negedge clk);
        req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        c0 = cyc;
        if (!req_ready) begin
            check("req_ready_timeout", 32'd0, 32'd1);
            req_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            c0 = cyc;
            req_valid = 1'b0;
            if (push) begin
                r.rdata = exp_rdata; r.err = exp_err; r.c0 = c0; r.lat = lat; r.kind = kind;
                rq.push_back(r);
                if (do_wr) begin
                    x.addr = addr[AW+1:2];
                    x.data = wexp;
                    wq.push_back(x);
                end
            end
        end
    endtask

    task automatic ld(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] exp);
        int c0;
        issue(1'b0, f3, addr, 32'd0, exp, 1'b0, RL + 1, 0, 1'b0, 32'd0, 1'b1, c0);
    endtask

    task automatic st(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                      input logic [31:0] wexp);
        int c0;
        issue(1'b1, f3, addr, wdata, 32'd0, 1'b0, (f3 == 3'b010) ? 1 : RL + 2, 1, 1'b1, wexp, 1'b1, c0);
    endtask

    task automatic bad(input logic we, input logic [2:0] f3, input logic [31:0] addr);
        int c0;
        issue(we, f3, addr, 32'hFFFF_FFFF, 32'd0, 1'b1, 0, 2, 1'b0, 32'd0, 1'b1, c0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_rsp_rdata"}, rsp_rdata, 32'd0);
        check({tag, "_rsp_err"}, 32'(rsp_err), 32'd0);
        check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({tag, "_mem_data_in"}, mem_data_in, 32'd0);
        check({tag, "_mem_we"}, 32'(mem_write_enable), 32'd0);
`ifdef LSU_STATS_EN
        check({tag, "_stat_loads"}, 32'(stat_loads), 32'd0);
        check({tag, "_stat_stores"}, 32'(stat_stores), 32'd0);
        check({tag, "_stat_faults"}, 32'(stat_faults), 32'd0);
`endif
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (rq.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("rsp_queue_drained", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        int c0;
        int n;
        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        st(3'b010, 32'h10, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        ld(3'b000, 32'h13, 32'hFFFF_FFDE);
        ld(3'b100, 32'h13, 32'h0000_00DE);
        ld(3'b001, 32'h10, 32'hFFFF_BEEF);
        ld(3'b101, 32'h12, 32'h0000_DEAD);
        st(3'b001, 32'h12, 32'h0000_1234, 32'h1234_BEEF);
        ld(3'b010, 32'h10, 32'h1234_BEEF);
        st(3'b000, 32'h11, 32'hFFFF_FFAB, 32'h1234_ABEF);
        ld(3'b010, 32'h10, 32'h1234_ABEF);
        ld(3'b000, 32'h11, 32'hFFFF_FFAB);
        st(3'b010, 32'hFFC, 32'hCAFE_F00D, 32'hCAFE_F00D);
        ld(3'b010, 32'hFFC, 32'hCAFE_F00D);

        bad(1'b0, 3'b010, 32'h11);
        bad(1'b1, 3'b001, 32'h13);
        bad(1'b0, 3'b011, 32'h10);
        bad(1'b0, 3'b010, 32'h1000);
        bad(1'b1, 3'b100, 32'h10);
        drain();

        // Consumer back-pressure: response must hold and new requests must be refused.
        rsp_ready = 1'b0;
        ld(3'b001, 32'h10, 32'hFFFF_ABEF);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("stall_rsp_seen", 32'(rsp_valid), 32'd1);
        repeat (5) begin
            @(negedge clk);
            req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20; req_valid = 1'b1;
            #3;
            check("stall_rsp_valid", 32'(rsp_valid), 32'd1);
            check("stall_rsp_rdata", rsp_rdata, 32'hFFFF_ABEF);
            check("stall_req_ready", 32'(req_ready), 32'd0);
        end
        @(negedge clk);
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        #3;
        check("post_stall_req_ready", 32'(req_ready), 32'd1);
        check("post_stall_rsp_valid", 32'(rsp_valid), 32'd0);
        drain();

`ifdef LSU_STATS_EN
        check("stat_loads", 32'(stat_loads), 32'(n_loads));
        check("stat_stores", 32'(stat_stores), 32'(n_stores));
        check("stat_faults", 32'(stat_faults), 32'(n_faults));
`endif

        // Reset landing in the write cycle of a read-modify-write byte store.
        issue(1'b1, 3'b000, 32'h10, 32'h0000_0055, 32'd0, 1'b0, 0, 1, 1'b0, 32'd0, 1'b0, c0);
        repeat (RL + 2) @(negedge clk);
        check("rmw_in_write_cycle", 32'(mem_write_enable), 32'd1);
        rst = 1'b1;
        #1;
        check("rst_forces_we_low", 32'(mem_write_enable), 32'd0);
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        n_loads = 0; n_stores = 0; n_faults = 0;
        repeat (3) begin
            @(negedge clk);
            #3;
            check("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end

        ld(3'b010, 32'h10, 32'h1234_ABEF);
        ld(3'b101, 32'h12, 32'h0000_1234);
        drain();
`ifdef LSU_STATS_EN
        check("stat_loads_after_rst", 32'(stat_loads), 32'(n_loads));
        check("stat_stores_after_rst", 32'(stat_stores), 32'(n_stores));
`endif
        repeat (2) @(negedge clk);
        check("write_queue_drained", 32'(wq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
